// File: rtl/uart_tx_scheduler.sv
// Byte transmit scheduler for a simple UART: a small write FIFO drained by a
// four-state sender FSM, plus a single-entry receive holding register.
module uart_tx_scheduler #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     tx_active_flag,
   input  logic                     tx_done_flag,
   input  logic                     rx_done_flag,
   input  logic [7:0]               data_out,
   input  logic                     rd_ack,
   output logic                     send,
   output logic [7:0]               data_in,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   output logic [2:0]               err,
   output logic [1:0]               fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   // Handshake: send is high for exactly the LOAD cycle and data_in is already
   // valid in that cycle; it then stays frozen until the frame completes or
   // times out. A write is taken whenever wr_en is high and a slot exists
   // (including the slot freed by a pop in the same cycle).
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_ACT  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [TW-1:0]   tmo_cnt;
   logic            push;
   logic            pop;
   logic            timeout_hit;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign pop       = (state == LOAD);
   assign push      = wr_en && (!full || pop);
   assign fsm_state = state;

   always_comb begin
      next_state  = state;
      send        = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !tx_active_flag) next_state = LOAD;
         end
         LOAD: begin
            send       = 1'b1;
            next_state = WAIT_ACT;
         end
         WAIT_ACT: begin
            if (tx_active_flag || tx_done_flag) begin
               next_state = WAIT_DONE;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               next_state  = IDLE;
            end
         end
         WAIT_DONE: begin
            if (tx_done_flag) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         data_in <= 8'h00;
         tmo_cnt <= '0;
      end else begin
         state <= next_state;
         // Head is latched on entry to LOAD so the byte accompanies the send pulse.
         if (state == IDLE && next_state == LOAD) data_in <= mem[rd_ptr];
         if (state == LOAD) tmo_cnt <= '0;
         else if (state == WAIT_ACT) tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         err      <= 3'b000;
      end else begin
         if (wr_en && full && !pop) err[0] <= 1'b1;
         if (timeout_hit)           err[2] <= 1'b1;
         if (rx_done_flag) begin
            rx_data  <= data_out;
            rx_valid <= 1'b1;
            if (rx_valid && !rd_ack) err[1] <= 1'b1;
         end else if (rd_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: scripted UART responses, a send scoreboard and
// a table of receive-path vectors.
module tb_uart_tx_scheduler;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 1024;
   localparam int CW      = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          tx_active_flag = 1'b0;
   logic          tx_done_flag = 1'b0;
   logic          rx_done_flag = 1'b0;
   logic [7:0]    data_out = 8'h00;
   logic          rd_ack = 1'b0;
   logic          send;
   logic [7:0]    data_in;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [2:0]    err;
   logic [1:0]    fsm_state;

   uart_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
      .rx_done_flag(rx_done_flag), .data_out(data_out), .rd_ack(rd_ack),
      .send(send), .data_in(data_in), .full(full), .empty(empty), .count(count),
      .rx_data(rx_data), .rx_valid(rx_valid), .err(err), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] last_exp = 8'h00;
   int send_cnt = 0;
   int last_send_cyc = 0;
   int last_done_cyc = 0;
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset && send) begin
         send_cnt++;
         last_send_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_send: got data_in %0h expected no send (cycle %0d)", data_in, cyc);
         end else begin
            last_exp = exp_q.pop_front();
            check("send_data", data_in, last_exp);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit accept);
      wr_en   = 1'b1;
      wr_data = b;
      if (accept) exp_q.push_back(b);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_send(input int max_cyc);
      int start;
      int n;
      start = send_cnt;
      n = 0;
      while (send_cnt == start && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (send_cnt == start) begin
         failures++;
         $display("FAIL wait_send: got no send expected one within %0d cycles", max_cyc);
      end
   endtask

   task automatic finish_frame();
      tx_active_flag = 1'b1;
      repeat (3) begin
         tick();
         check("data_in_hold", data_in, last_exp);
      end
      tx_active_flag = 1'b0;
      tx_done_flag   = 1'b1;
      last_done_cyc  = cyc;
      tick();
      tx_done_flag = 1'b0;
      check("data_in_hold_done", data_in, last_exp);
   endtask

   typedef struct {
      logic       done;
      logic [7:0] data;
      logic       ack;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_err;
   } rx_vec_t;

   rx_vec_t rx_tab[10];

   initial begin
      int w_cyc;
      int l_cyc;
      int n;
      int snap;

      rx_tab[0] = '{1'b1, 8'h55, 1'b0, 8'h55, 1'b1, 1'b0};
      rx_tab[1] = '{1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
      rx_tab[2] = '{1'b0, 8'($urandom_range(0, 255)), 1'b1, 8'h5A, 1'b0, 1'b0};
      rx_tab[3] = '{1'b0, 8'($urandom_range(0, 255)), 1'b0, 8'h5A, 1'b0, 1'b0};
      rx_tab[4] = '{1'b1, 8'h55, 1'b0, 8'h55, 1'b1, 1'b0};
      rx_tab[5] = '{1'b1, 8'h66, 1'b0, 8'h66, 1'b1, 1'b1};
      rx_tab[6] = '{1'b0, 8'($urandom_range(0, 255)), 1'b0, 8'h66, 1'b1, 1'b1};
      rx_tab[7] = '{1'b0, 8'($urandom_range(0, 255)), 1'b1, 8'h66, 1'b0, 1'b1};
      rx_tab[8] = '{1'b1, 8'hC3, 1'b0, 8'hC3, 1'b1, 1'b1};
      rx_tab[9] = '{1'b0, 8'($urandom_range(0, 255)), 1'b1, 8'hC3, 1'b0, 1'b1};

      // reset values and quiet start
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("rst_send", send, 0);
      check("rst_data_in", data_in, 8'h00);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_err", err, 3'b000);
      check("rst_state", fsm_state, 0);
      repeat (10) tick();
      check("no_send_after_reset", send_cnt, 0);

      // receive path vectors
      for (int i = 0; i < 10; i++) begin
         rx_done_flag = rx_tab[i].done;
         data_out     = rx_tab[i].data;
         rd_ack       = rx_tab[i].ack;
         tick();
         rx_done_flag = 1'b0;
         rd_ack       = 1'b0;
         check($sformatf("rx_data_%0d", i), rx_data, rx_tab[i].exp_data);
         check($sformatf("rx_valid_%0d", i), rx_valid, rx_tab[i].exp_valid);
         check($sformatf("rx_err_%0d", i), err[1], rx_tab[i].exp_err);
      end

      // single byte, UART idle: send two cycles after the write
      w_cyc = cyc;
      write_byte(8'h41, 1'b1);
      wait_send(10);
      check("send_latency", last_send_cyc, w_cyc + 2);
      finish_frame();
      check("single_count", count, 0);
      check("single_empty", empty, 1);

      // overflow while UART busy, then ordered drain with minimum spacing
      tx_active_flag = 1'b1;
      for (int i = 1; i <= 5; i++) write_byte(8'(i), i <= DEPTH);
      check("ovf_count", count, DEPTH);
      check("ovf_full", full, 1);
      check("ovf_err0", err[0], 1);
      check("ovf_no_send", send_cnt, 1);
      tx_active_flag = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wait_send(20);
         if (i > 0) check("b2b_spacing", last_send_cyc, last_done_cyc + 2);
         finish_frame();
      end
      check("ovf_drained", count, 0);

      // write while full in the pop cycle is accepted
      tx_active_flag = 1'b1;
      write_byte(8'h11, 1'b1);
      write_byte(8'h22, 1'b1);
      write_byte(8'h33, 1'b1);
      write_byte(8'h44, 1'b1);
      check("fill_full", full, 1);
      tx_active_flag = 1'b0;
      tick();
      check("load_state", fsm_state, 1);
      write_byte(8'hAA, 1'b1);
      check("pop_push_count", count, DEPTH);
      check("pop_push_full", full, 1);
      finish_frame();
      for (int i = 0; i < DEPTH; i++) begin
         wait_send(20);
         finish_frame();
      end
      check("pop_push_drained", empty, 1);

      // activity timeout
      write_byte(8'h77, 1'b1);
      write_byte(8'h78, 1'b1);
      wait_send(10);
      l_cyc = last_send_cyc;
      n = 0;
      while (cyc < l_cyc + TIMEOUT && n < TIMEOUT + 10) begin
         tick();
         n++;
      end
      check("tmo_err_before", err[2], 0);
      check("tmo_state_before", fsm_state, 2);
      tick();
      check("tmo_err_after", err[2], 1);
      check("tmo_state_idle", fsm_state, 0);
      wait_send(10);
      check("tmo_next_send", last_send_cyc, l_cyc + TIMEOUT + 2);
      finish_frame();

      // reset during WAIT_DONE with three bytes queued
      write_byte(8'hB1, 1'b1);
      wait_send(10);
      tx_active_flag = 1'b1;
      tick();
      write_byte(8'hB2, 1'b1);
      write_byte(8'hB3, 1'b1);
      write_byte(8'hB4, 1'b1);
      check("pre_rst_state", fsm_state, 3);
      check("pre_rst_count", count, 3);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_send", send, 0);
      check("mid_rst_data_in", data_in, 8'h00);
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_full", full, 0);
      check("mid_rst_rx_valid", rx_valid, 0);
      check("mid_rst_rx_data", rx_data, 8'h00);
      check("mid_rst_err", err, 3'b000);
      check("mid_rst_state", fsm_state, 0);
      tick();
      tx_active_flag = 1'b0;
      reset = 1'b1;
      snap = send_cnt;
      repeat (20) tick();
      check("post_rst_no_send", send_cnt, snap);

      check("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
